// File: rtl/vt_rng_model.sv
// Seeded dual-LFSR noise source: a 24-bit and a 16-bit Fibonacci LFSR, whose
// upper 12 bits are XORed into a registered sample each clock.
module vt_rng_model (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] data,
  input  logic [15:0] data2,
  output logic [11:0] x
);

  localparam int unsigned AW = 24;
  localparam int unsigned BW = 16;
  localparam int unsigned XW = 12;

  logic [AW-1:0] lfsr_a;
  logic [BW-1:0] lfsr_b;
  logic          seeded;

  logic [AW-1:0] a_seed;
  logic [BW-1:0] b_seed;
  logic [AW-1:0] a_step;
  logic [BW-1:0] b_step;
  logic [XW-1:0] x_next;

  // An all-zero seed would lock an LFSR, so it is replaced by 1.
  always_comb begin
    a_seed = data;
    b_seed = data2;
    if (data == AW'(0)) a_seed = AW'(1);
    if (data2 == BW'(0)) b_seed = BW'(1);
  end

  // x^24+x^23+x^22+x^17+1 and x^16+x^15+x^13+x^4+1
  always_comb begin
    a_step = {lfsr_a[AW-2:0], lfsr_a[23] ^ lfsr_a[22] ^ lfsr_a[21] ^ lfsr_a[16]};
    b_step = {lfsr_b[BW-2:0], lfsr_b[15] ^ lfsr_b[14] ^ lfsr_b[12] ^ lfsr_b[3]};
    x_next = lfsr_a[AW-1:AW-XW] ^ lfsr_b[BW-1:BW-XW];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_a <= '0;
      lfsr_b <= '0;
      seeded <= 1'b0;
      x      <= '0;
    end else if (!seeded) begin
      lfsr_a <= a_seed;
      lfsr_b <= b_seed;
      seeded <= 1'b1;
    end else begin
      lfsr_a <= a_step;
      lfsr_b <= b_step;
      x      <= x_next;
    end
  end

endmodule

// File: tb/tb_vt_rng_model.sv
// Directed bench for vt_rng_model: reset behaviour, hand-computed first
// samples, and long runs against a software model of both LFSRs.
module tb_vt_rng_model;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] data = '0;
  logic [15:0] data2 = '0;
  logic [11:0] x;

  int unsigned total = 0;
  int unsigned passed = 0;

  vt_rng_model dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .data2 (data2),
    .x     (x)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] step_a(input logic [23:0] a);
    return {a[22:0], a[23] ^ a[22] ^ a[21] ^ a[16]};
  endfunction

  function automatic logic [15:0] step_b(input logic [15:0] b);
    return {b[14:0], b[15] ^ b[14] ^ b[12] ^ b[3]};
  endfunction

  task automatic check_x(input string name, input logic [11:0] exp);
    total++;
    if (x !== exp) $display("FAIL %s: x=%h expected %h", name, x, exp);
    else passed++;
  endtask

  // Pulse reset, present seeds, release; returns just after the load edge.
  task automatic load_seeds(input logic [23:0] sa, input logic [15:0] sb);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    data  = sa;
    data2 = sb;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Compare n samples after the load edge against the reference LFSRs.
  task automatic run_model(input string name, input logic [23:0] sa,
                           input logic [15:0] sb, input int n, input bit scramble);
    logic [23:0] ma;
    logic [15:0] mb;
    logic [11:0] exp;
    int errs = 0;
    int zeros = 0;
    ma = (sa == 24'h0) ? 24'h000001 : sa;
    mb = (sb == 16'h0) ? 16'h0001 : sb;
    for (int i = 0; i < n; i++) begin
      if (scramble) begin
        data  = 24'($urandom);
        data2 = 16'($urandom);
      end
      @(negedge clk);
      exp = ma[23:12] ^ mb[15:4];
      if (x !== exp) errs++;
      if (dut.lfsr_a == 24'h0 || dut.lfsr_b == 16'h0) zeros++;
      ma = step_a(ma);
      mb = step_b(mb);
    end
    total++;
    if (errs != 0) $display("FAIL %s: %0d sample mismatches, expected 0", name, errs);
    else passed++;
    total++;
    if (zeros != 0) $display("FAIL %s_nonzero: %0d cycles with zero LFSR, expected 0", name, zeros);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    check_x("reset_async", 12'h000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_x("reset_hold", 12'h000);
    end
  endtask

  task automatic test_nominal();
    load_seeds(24'h6ABE62, 16'h223D);
    check_x("nom_load", 12'h000);
    @(negedge clk); check_x("nom_edge2", 12'h488);
    @(negedge clk); check_x("nom_edge3", 12'h910);
    @(negedge clk); check_x("nom_edge4", 12'h220);
  endtask

  task automatic test_model_run();
    load_seeds(24'h6ABE62, 16'h223D);
    run_model("nom_model", 24'h6ABE62, 16'h223D, 4000, 1'b0);
  endtask

  task automatic test_zero_seeds();
    load_seeds(24'h0, 16'h0);
    check_x("zero_load", 12'h000);
    @(negedge clk); check_x("zero_edge2", 12'h000);
    load_seeds(24'h0, 16'h0);
    run_model("zero_model", 24'h0, 16'h0, 3000, 1'b0);
  endtask

  task automatic test_seed_change();
    load_seeds(24'h6ABE62, 16'h223D);
    run_model("seed_change", 24'h6ABE62, 16'h223D, 200, 1'b1);
  endtask

  task automatic test_mid_reset();
    load_seeds(24'h6ABE62, 16'h223D);
    repeat (500) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_x("mid_async", 12'h000);
    @(negedge clk);
    check_x("mid_hold", 12'h000);
    reset = 1'b0;
    @(negedge clk); check_x("mid_load", 12'h000);
    @(negedge clk); check_x("mid_edge2", 12'h488);
    @(negedge clk); check_x("mid_edge3", 12'h910);
    @(negedge clk); check_x("mid_edge4", 12'h220);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_model_run();
    test_zero_seeds();
    test_seed_change();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
